// File: rtl/dm_arbiter_if.sv
// Requester ports A/B plus the data-memory side of the arbiter, bundled as one interface.
interface dm_arbiter_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) ();
  logic                  req_a, req_b;
  logic                  we_a, we_b;
  logic                  lock_a, lock_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
  logic                  gnt_a, gnt_b;
  logic                  rvalid_a, rvalid_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  lock_timeout;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  req_a, req_b, we_a, we_b, lock_a, lock_b,
    input  addr_a, addr_b, wdata_a, wdata_b, mem_dout,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
    output lock_timeout, mem_addr, mem_we, mem_din
  );

  modport master (
    output req_a, req_b, we_a, we_b, lock_a, lock_b,
    output addr_a, addr_b, wdata_a, wdata_b, mem_dout,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
    input  lock_timeout, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: zero-latency grant, round-robin or A-priority, lock with idle timeout.
// Read data registered one cycle after grant; losers simply keep req high.
module dm_arbiter #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int A_PRIORITY   = 0,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_arbiter_if.slave bus
);

  localparam logic [1:0] FREE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;
  localparam logic [7:0] TO_LIM = 8'(LOCK_TIMEOUT);
  localparam logic       A_PRI  = (A_PRIORITY != 0);

  logic [1:0]            state_q, state_d;
  logic                  last_b_q, last_b_d;
  logic [7:0]            idle_cnt_q, idle_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rvalid_a_q, rvalid_b_q;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;

  logic elig_a, elig_b, win_a, win_b, own_idle, timeout;

  // Grants are gated by rst_n so every output reads as idle while reset is held.
  always_comb begin
    elig_a   = rst_n & bus.req_a & (state_q != OWN_B);
    elig_b   = rst_n & bus.req_b & (state_q != OWN_A);
    win_a    = elig_a & (~elig_b | A_PRI | last_b_q);
    win_b    = elig_b & ~win_a;
    own_idle = ((state_q == OWN_A) & ~bus.req_a) | ((state_q == OWN_B) & ~bus.req_b);
    timeout  = own_idle & (idle_cnt_q == TO_LIM);
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    idle_cnt_d = idle_cnt_q;
    addr_d     = addr_q;
    din_d      = din_q;
    if (win_a) begin
      state_d    = bus.lock_a ? OWN_A : FREE;
      last_b_d   = 1'b0;
      idle_cnt_d = 8'd0;
      addr_d     = bus.addr_a;
      din_d      = bus.wdata_a;
    end else if (win_b) begin
      state_d    = bus.lock_b ? OWN_B : FREE;
      last_b_d   = 1'b1;
      idle_cnt_d = 8'd0;
      addr_d     = bus.addr_b;
      din_d      = bus.wdata_b;
    end else if (timeout) begin
      state_d    = FREE;
      idle_cnt_d = 8'd0;
    end else if (own_idle) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FREE;
      last_b_q   <= 1'b1;
      idle_cnt_q <= 8'd0;
      addr_q     <= '0;
      din_q      <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      idle_cnt_q <= idle_cnt_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rvalid_a_q <= win_a & ~bus.we_a;
      rvalid_b_q <= win_b & ~bus.we_b;
      if (win_a & ~bus.we_a) rdata_a_q <= bus.mem_dout;
      if (win_b & ~bus.we_b) rdata_b_q <= bus.mem_dout;
    end
  end

  // With no winner the address/data hold their last granted values so the memory sees a stable bus.
  assign bus.gnt_a        = win_a;
  assign bus.gnt_b        = win_b;
  assign bus.mem_addr     = win_a ? bus.addr_a  : (win_b ? bus.addr_b  : addr_q);
  assign bus.mem_din      = win_a ? bus.wdata_a : (win_b ? bus.wdata_b : din_q);
  assign bus.mem_we       = (win_a & bus.we_a) | (win_b & bus.we_b);
  assign bus.rvalid_a     = rvalid_a_q;
  assign bus.rvalid_b     = rvalid_b_q;
  assign bus.rdata_a      = rdata_a_q;
  assign bus.rdata_b      = rdata_b_q;
  assign bus.lock_timeout = timeout;

endmodule
